// File: rtl/matmul_pkg.sv
// Shared encodings, FSM state type and the round/saturate helper for matmul_seq.
package matmul_pkg;

    localparam logic [1:0] MODE_SQ  = 2'd0;
    localparam logic [1:0] MODE_MUL = 2'd1;
    localparam logic [1:0] MODE_BYP = 2'd2;

    // Widest element supported and the working width of the rounding helper.
    localparam int unsigned MAX_W   = 32;
    localparam int unsigned ACC_MAX = 2 * MAX_W + 8;

    typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

    // Returns {sat_bit, value}; the caller keeps the low w bits of value.
    function automatic logic [MAX_W:0] rnd_sat(input logic signed [ACC_MAX-1:0] acc,
                                               input int unsigned w,
                                               input int unsigned frac);
        logic signed [ACC_MAX-1:0] half;
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        logic signed [ACC_MAX-1:0] r;
        logic [MAX_W:0] res;
        half = ACC_MAX'(1) << (frac - 1);
        hi   = (ACC_MAX'(1) << (w - 1)) - ACC_MAX'(1);
        lo   = ~hi;
        r    = (acc + half) >>> frac;
        res  = '0;
        if (r > hi) begin
            res[MAX_W] = 1'b1;
            r          = hi;
        end else if (r < lo) begin
            res[MAX_W] = 1'b1;
            r          = lo;
        end
        res[MAX_W-1:0] = r[MAX_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/mm_dot.sv
// Combinational N-term signed dot product, rounded and saturated back to W bits.
module mm_dot
    import matmul_pkg::*;
#(
    parameter int unsigned W    = 26,
    parameter int unsigned FRAC = 13,
    parameter int unsigned N    = 4
) (
    input  logic [N*W-1:0] row,
    input  logic [N*W-1:0] col,
    output logic [W-1:0]   val,
    output logic           sat
);

    // Wide enough that N full-scale products cannot overflow.
    localparam int unsigned AW = 2 * W + $clog2(N);

    logic signed [AW-1:0]    acc;
    logic signed [W-1:0]     a_k;
    logic signed [W-1:0]     b_k;
    logic signed [2*W-1:0]   prod;
    logic        [MAX_W:0]   rs;

    always_comb begin
        acc  = '0;
        a_k  = '0;
        b_k  = '0;
        prod = '0;
        for (int k = 0; k < int'(N); k++) begin
            a_k  = row[k*W +: W];
            b_k  = col[k*W +: W];
            prod = a_k * b_k;
            acc  = acc + AW'(prod);
        end
        rs  = rnd_sat(ACC_MAX'(acc), W, FRAC);
        val = rs[W-1:0];
        sat = rs[MAX_W];
    end

endmodule

// File: rtl/matmul_seq.sv
// Time-multiplexed per-channel matrix square/product/bypass, one C element per channel per cycle.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int unsigned W    = 26,
    parameter int unsigned FRAC = 13,
    parameter int unsigned N    = 4,
    parameter int unsigned CH   = 4
) (
    input  logic                clk_mul,
    input  logic                rst_mul_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic [CH*N*N*W-1:0] a_flat,
    input  logic [CH*N*N*W-1:0] b_flat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*N*N*W-1:0] c_flat,
    output logic [CH-1:0]       sat,
    output logic                busy
);

    localparam int unsigned NN  = N * N;
    localparam int unsigned TOT = CH * NN * W;
    localparam int unsigned IW  = $clog2(NN);

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic [1:0]      mode_q;
    logic [TOT-1:0]  a_q;
    logic [TOT-1:0]  b_q;
    logic [TOT-1:0]  c_q;
    logic [CH-1:0]   sat_q;

    logic [CH*N*W-1:0] rows;
    logic [CH*N*W-1:0] cols;
    logic [CH*W-1:0]   dot_val;
    logic [CH-1:0]     dot_sat;
    int unsigned       r_sel;
    int unsigned       c_sel;

    // Row r of A and column c of X (B in product mode, A otherwise) for every channel.
    always_comb begin
        r_sel = 32'(idx_q) / N;
        c_sel = 32'(idx_q) % N;
        rows  = '0;
        cols  = '0;
        for (int ch = 0; ch < int'(CH); ch++) begin
            for (int k = 0; k < int'(N); k++) begin
                rows[(ch*N + k)*W +: W] = a_q[((ch*N + r_sel)*N + k)*W +: W];
                cols[(ch*N + k)*W +: W] = (mode_q == MODE_MUL) ?
                                          b_q[((ch*N + k)*N + c_sel)*W +: W] :
                                          a_q[((ch*N + k)*N + c_sel)*W +: W];
            end
        end
    end

    for (genvar ch = 0; ch < CH; ch++) begin : g_dot
        mm_dot #(
            .W    (W),
            .FRAC (FRAC),
            .N    (N)
        ) u_dot (
            .row (rows[ch*N*W +: N*W]),
            .col (cols[ch*N*W +: N*W]),
            .val (dot_val[ch*W +: W]),
            .sat (dot_sat[ch])
        );
    end

    always_ff @(posedge clk_mul or negedge rst_mul_n) begin
        if (!rst_mul_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            mode_q  <= MODE_SQ;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            sat_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q    <= a_flat;
                        b_q    <= b_flat;
                        mode_q <= mode;
                        idx_q  <= '0;
                        sat_q  <= '0;
                        if (mode == MODE_BYP) begin
                            c_q     <= a_flat;
                            state_q <= StHold;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    // Element (r, c) sits at flat index r*N + c, which is just idx.
                    for (int ch = 0; ch < int'(CH); ch++) begin
                        c_q[(ch*NN + 32'(idx_q))*W +: W] <= dot_val[ch*W +: W];
                    end
                    sat_q <= sat_q | dot_sat;
                    if (32'(idx_q) == NN - 1) begin
                        state_q <= StHold;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StHold);
    assign c_flat    = c_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq against a plain matrix-arithmetic reference model.
module tb_matmul_seq;

    localparam int W    = 26;
    localparam int FRAC = 13;
    localparam int N    = 4;
    localparam int CH   = 4;
    localparam int NN   = N * N;
    localparam int TOT  = CH * NN * W;
    localparam int ONE  = 8192;

    logic           clk_mul   = 1'b0;
    logic           rst_mul_n = 1'b0;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic [1:0]     mode      = 2'd0;
    logic [TOT-1:0] a_flat    = '0;
    logic [TOT-1:0] b_flat    = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [TOT-1:0] c_flat;
    logic [CH-1:0]  sat;
    logic           busy;

    int n_cmp = 0;
    int n_err = 0;

    int             ma [CH][N][N];
    int             mb [CH][N][N];
    logic [TOT-1:0] exp_c;
    logic [CH-1:0]  exp_sat;

    matmul_seq #(
        .W    (W),
        .FRAC (FRAC),
        .N    (N),
        .CH   (CH)
    ) dut (
        .clk_mul   (clk_mul),
        .rst_mul_n (rst_mul_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_flat    (c_flat),
        .sat       (sat),
        .busy      (busy)
    );

    always #5 clk_mul = ~clk_mul;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: C = A*X as integer matrix math, then floor((sum + half) / 2^FRAC) and clamp.
    function automatic void model(input logic [1:0] m);
        longint sum;
        longint v;
        longint hi;
        longint lo;
        hi      = (longint'(1) <<< (W - 1)) - 1;
        lo      = -hi - 1;
        exp_c   = '0;
        exp_sat = '0;
        for (int ch = 0; ch < CH; ch++) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (m == 2'd2) begin
                        v = longint'(ma[ch][r][c]);
                    end else begin
                        sum = 0;
                        for (int k = 0; k < N; k++) begin
                            sum += longint'(ma[ch][r][k]) *
                                   longint'((m == 2'd1) ? mb[ch][k][c] : ma[ch][k][c]);
                        end
                        v = (sum + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
                        if (v > hi) begin
                            v = hi;
                            exp_sat[ch] = 1'b1;
                        end else if (v < lo) begin
                            v = lo;
                            exp_sat[ch] = 1'b1;
                        end
                    end
                    exp_c[((ch*N + r)*N + c)*W +: W] = v[W-1:0];
                end
            end
        end
    endfunction

    function automatic int rnd_elem(input int bits);
        return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
    endfunction

    task automatic clear_ops();
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    ma[ch][r][c] = 0;
                    mb[ch][r][c] = 0;
                end
    endtask

    task automatic ident(input int diag);
        clear_ops();
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < N; r++) ma[ch][r][r] = diag;
    endtask

    task automatic random_ops(input int bits);
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    ma[ch][r][c] = rnd_elem(bits);
                    mb[ch][r][c] = rnd_elem(bits);
                end
    endtask

    task automatic drive_ops();
        int ta;
        int tb;
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    ta = ma[ch][r][c];
                    tb = mb[ch][r][c];
                    a_flat[((ch*N + r)*N + c)*W +: W] = ta[W-1:0];
                    b_flat[((ch*N + r)*N + c)*W +: W] = tb[W-1:0];
                end
    endtask

    // Returns just after the acceptance edge E0 (+1 time unit).
    task automatic accept(input logic [1:0] m);
        @(negedge clk_mul);
        mode = m;
        drive_ops();
        in_valid = 1'b1;
        @(posedge clk_mul);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts clock edges after E0 until out_valid is seen; 0 means high right after E0.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk_mul);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk_mul);
        out_ready = 1'b1;
        @(posedge clk_mul);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 100", {in_ready, out_valid, busy});
        end
        n_cmp++;
        if (c_flat !== '0 || sat !== '0) begin
            n_err++;
            $display("FAIL reset_data: got c=%h sat=%b expected zero", c_flat, sat);
        end
        @(negedge clk_mul);
        rst_mul_n = 1'b1;
    endtask

    task automatic test_identity();
        int lat;
        ident(ONE);
        model(2'd0);
        accept(2'd0);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL ident_busy: got ov=%b busy=%b expected 0 1", out_valid, busy);
        end
        wait_out(lat);
        n_cmp++;
        if (lat !== NN) begin
            n_err++;
            $display("FAIL ident_latency: got %0d expected %0d", lat, NN);
        end
        n_cmp++;
        if (c_flat !== exp_c || sat !== 4'b0000) begin
            n_err++;
            $display("FAIL ident_result: got %h sat %b expected %h sat 0000", c_flat, sat, exp_c);
        end
        release_out();
    endtask

    task automatic test_product();
        int lat;
        ident(2 * ONE);
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) mb[ch][r][c] = 12288;
        model(2'd1);
        accept(2'd1);
        wait_out(lat);
        n_cmp++;
        if (c_flat !== exp_c || sat !== 4'b0000) begin
            n_err++;
            $display("FAIL product: got %h sat %b expected %h sat 0000", c_flat, sat, exp_c);
        end
        n_cmp++;
        if ($signed(c_flat[(NN*CH-1)*W +: W]) !== 26'sd24576) begin
            n_err++;
            $display("FAIL product_last: got %0d expected 24576",
                     $signed(c_flat[(NN*CH-1)*W +: W]));
        end
        release_out();
    endtask

    task automatic test_rounding();
        int lat;
        int a00;
        int want;
        for (int pass = 0; pass < 2; pass++) begin
            a00  = (pass == 0) ? 1 : -1;
            want = (pass == 0) ? 1 : 0;
            clear_ops();
            for (int ch = 0; ch < CH; ch++) begin
                ma[ch][0][0] = a00;
                mb[ch][0][0] = 4096;
            end
            model(2'd1);
            accept(2'd1);
            wait_out(lat);
            n_cmp++;
            if ($signed(c_flat[W-1:0]) !== want) begin
                n_err++;
                $display("FAIL round_c00: got %0d expected %0d", $signed(c_flat[W-1:0]), want);
            end
            n_cmp++;
            if (c_flat !== exp_c || sat !== exp_sat) begin
                n_err++;
                $display("FAIL round_all: got %h expected %h", c_flat, exp_c);
            end
            release_out();
        end
    endtask

    task automatic test_saturation();
        int lat;
        clear_ops();
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    ma[ch][r][c] = 1 << 24;
                    if (ch == 0) mb[ch][r][c] = 1 << 24;
                    if (ch == 1) mb[ch][r][c] = -(1 << 24);
                end
        model(2'd1);
        accept(2'd1);
        wait_out(lat);
        n_cmp++;
        if (sat !== 4'b0011) begin
            n_err++;
            $display("FAIL sat_flags: got %b expected 0011", sat);
        end
        n_cmp++;
        if ($signed(c_flat[0 +: W]) !== 33554431 || $signed(c_flat[NN*W +: W]) !== -33554432) begin
            n_err++;
            $display("FAIL sat_clamp: got %0d %0d expected 33554431 -33554432",
                     $signed(c_flat[0 +: W]), $signed(c_flat[NN*W +: W]));
        end
        n_cmp++;
        if (c_flat !== exp_c) begin
            n_err++;
            $display("FAIL sat_all: got %h expected %h", c_flat, exp_c);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        random_ops(16);
        model(2'd1);
        accept(2'd1);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_mul);
            in_valid = 1'($urandom);
            mode     = 2'($urandom);
            a_flat   = {TOT/32 + 1{$urandom}};
            b_flat   = {TOT/32 + 1{$urandom}};
            @(posedge clk_mul);
            #1;
            n_cmp++;
            if (c_flat !== exp_c || sat !== exp_sat || in_ready !== 1'b0 || out_valid !== 1'b1)
            begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got c=%h sat=%b ir=%b ov=%b expected c=%h sat=%b 0 1",
                         i, c_flat, sat, in_ready, out_valid, exp_c, exp_sat);
            end
        end
        @(negedge clk_mul);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk_mul);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: got ir=%b ov=%b expected 1 0", in_ready, out_valid);
        end
        repeat (3) @(posedge clk_mul);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_no_accept: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_bypass();
        int lat;
        random_ops(W);
        model(2'd2);
        accept(2'd2);
        wait_out(lat);
        n_cmp++;
        if (lat !== 0) begin
            n_err++;
            $display("FAIL bypass_latency: got %0d expected 0 extra edges", lat);
        end
        n_cmp++;
        if (c_flat !== exp_c || sat !== 4'b0000) begin
            n_err++;
            $display("FAIL bypass_data: got %h sat %b expected %h sat 0000", c_flat, sat, exp_c);
        end
        release_out();
    endtask

    task automatic test_reset_abort();
        int lat;
        ident(ONE);
        accept(2'd0);
        repeat (5) @(posedge clk_mul);
        #2;
        rst_mul_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || c_flat !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset: got ov=%b ir=%b busy=%b c=%h expected 0 1 0 zero",
                     out_valid, in_ready, busy, c_flat);
        end
        @(negedge clk_mul);
        rst_mul_n = 1'b1;
        ident(ONE);
        model(2'd0);
        accept(2'd0);
        wait_out(lat);
        n_cmp++;
        if (lat !== NN || c_flat !== exp_c || sat !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_rerun: got lat=%0d c=%h expected lat=%0d c=%h",
                     lat, c_flat, NN, exp_c);
        end
        release_out();
    endtask

    // out_ready already high: one HOLD cycle, then a new request at the minimum period.
    task automatic test_back_to_back();
        int lat;
        for (int t = 0; t < 2; t++) begin
            random_ops(20);
            model(2'd0);
            accept(2'd0);
            out_ready = 1'b1;
            wait_out(lat);
            n_cmp++;
            if (lat !== NN || c_flat !== exp_c || sat !== exp_sat) begin
                n_err++;
                $display("FAIL b2b_result[%0d]: got lat=%0d c=%h sat=%b expected %0d %h %b",
                         t, lat, c_flat, sat, NN, exp_c, exp_sat);
            end
            @(posedge clk_mul);
            #1;
            out_ready = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_onecycle[%0d]: got ov=%b ir=%b expected 0 1",
                         t, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [1:0]  m;
        for (int t = 0; t < 12; t++) begin
            m = 2'($urandom);
            random_ops(int'($urandom_range(8, W)));
            model(m);
            accept(m);
            wait_out(lat);
            n_cmp++;
            if (lat !== ((m == 2'd2) ? 0 : NN) || c_flat !== exp_c || sat !== exp_sat) begin
                n_err++;
                $display("FAIL random[%0d] mode %0d: got lat=%0d c=%h sat=%b expected c=%h sat=%b",
                         t, m, lat, c_flat, sat, exp_c, exp_sat);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_product();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_bypass();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
